// File: rtl/vga_fml_arb_pkg.sv
// Shared encodings for the VGA FML arbiter.
// FSM states, grant ids and default burst length.
package vga_fml_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] REQ   = 2'd1;
  localparam logic [1:0] BURST = 2'd2;

  localparam logic GNT_CPU = 1'b0;
  localparam logic GNT_LCD = 1'b1;

  localparam int BURST_LEN_DEF = 4;

endpackage

// File: rtl/vga_fml_arb.sv
// Two-master FML arbiter: CPU bridge and LCD scan-out
// share one downstream FML port toward the SDRAM controller.
module vga_fml_arb
  import vga_fml_pkg::*;
#(
  parameter int fml_depth = 20,
  parameter int burst_len = BURST_LEN_DEF
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,

  input  logic [fml_depth-1:0] cpu_fml_adr,
  input  logic                 cpu_fml_stb,
  input  logic                 cpu_fml_we,
  input  logic [1:0]           cpu_fml_sel,
  input  logic [15:0]          cpu_fml_do,
  output logic                 cpu_fml_ack,
  output logic [15:0]          cpu_fml_di,

  input  logic [fml_depth-1:0] lcd_fml_adr,
  input  logic                 lcd_fml_stb,
  input  logic                 lcd_fml_we,
  input  logic [1:0]           lcd_fml_sel,
  input  logic [15:0]          lcd_fml_do,
  output logic                 lcd_fml_ack,
  output logic [15:0]          lcd_fml_di,

  output logic [fml_depth-1:0] fml_adr,
  output logic                 fml_stb,
  output logic                 fml_we,
  input  logic                 fml_ack,
  output logic [1:0]           fml_sel,
  output logic [15:0]          fml_do,
  input  logic [15:0]          fml_di
);

  localparam int CW =
    (burst_len > 1) ? $clog2(burst_len) : 1;
  localparam logic [CW-1:0] LAST = CW'(burst_len - 1);

  logic [1:0]    state;
  logic          grant;
  logic          last_grant;
  logic          pick;
  logic [CW-1:0] cnt;

  // Round-robin pick; a tie goes to whoever lost last time.
  always_comb begin
    pick = GNT_CPU;
    if (cpu_fml_stb && lcd_fml_stb)
      pick = ~last_grant;
    else if (lcd_fml_stb)
      pick = GNT_LCD;
  end

  // Arbitration FSM, beat counter and registered address/we.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= IDLE;
      grant      <= GNT_CPU;
      last_grant <= GNT_CPU;
      cnt        <= '0;
      fml_adr    <= '0;
      fml_we     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_fml_stb || lcd_fml_stb) begin
            grant      <= pick;
            last_grant <= pick;
            fml_adr    <= (pick == GNT_LCD) ?
                          lcd_fml_adr : cpu_fml_adr;
            fml_we     <= (pick == GNT_LCD) ?
                          lcd_fml_we : cpu_fml_we;
            state      <= REQ;
          end
        end
        REQ: begin
          if (fml_ack) begin
            cnt   <= '0;
            state <= BURST;
          end
        end
        BURST: begin
          cnt <= cnt + CW'(1);
          if (cnt == LAST)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Burst data/select steering; zero outside the burst.
  always_comb begin
    fml_sel = 2'b00;
    fml_do  = 16'h0000;
    if (state == BURST) begin
      fml_sel = (grant == GNT_LCD) ?
                lcd_fml_sel : cpu_fml_sel;
      fml_do  = (grant == GNT_LCD) ?
                lcd_fml_do : cpu_fml_do;
    end
  end

  assign fml_stb = (state == REQ);

  assign cpu_fml_ack =
    fml_stb & fml_ack & (grant == GNT_CPU);
  assign lcd_fml_ack =
    fml_stb & fml_ack & (grant == GNT_LCD);

  assign cpu_fml_di = fml_di;
  assign lcd_fml_di = fml_di;

endmodule

// File: tb/tb_vga_fml_arb.sv
// Directed bench for vga_fml_arb.
// Drives at negedge, samples 1ns later.
module tb_vga_fml_arb;
  import vga_fml_pkg::*;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [19:0] cpu_fml_adr, lcd_fml_adr;
  logic        cpu_fml_stb, lcd_fml_stb;
  logic        cpu_fml_we, lcd_fml_we;
  logic [1:0]  cpu_fml_sel, lcd_fml_sel;
  logic [15:0] cpu_fml_do, lcd_fml_do;
  logic        cpu_fml_ack, lcd_fml_ack;
  logic [15:0] cpu_fml_di, lcd_fml_di;
  logic [19:0] fml_adr;
  logic        fml_stb, fml_we, fml_ack;
  logic [1:0]  fml_sel;
  logic [15:0] fml_do, fml_di;

  int n_tests = 0;
  int n_fail  = 0;

  vga_fml_arb dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .cpu_fml_adr(cpu_fml_adr), .cpu_fml_stb(cpu_fml_stb),
    .cpu_fml_we(cpu_fml_we), .cpu_fml_sel(cpu_fml_sel),
    .cpu_fml_do(cpu_fml_do), .cpu_fml_ack(cpu_fml_ack),
    .cpu_fml_di(cpu_fml_di),
    .lcd_fml_adr(lcd_fml_adr), .lcd_fml_stb(lcd_fml_stb),
    .lcd_fml_we(lcd_fml_we), .lcd_fml_sel(lcd_fml_sel),
    .lcd_fml_do(lcd_fml_do), .lcd_fml_ack(lcd_fml_ack),
    .lcd_fml_di(lcd_fml_di),
    .fml_adr(fml_adr), .fml_stb(fml_stb), .fml_we(fml_we),
    .fml_ack(fml_ack), .fml_sel(fml_sel), .fml_do(fml_do),
    .fml_di(fml_di)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge sys_clk);
  endtask

  task automatic chk_idle_outs(input string tag);
    check({tag, "_stb"}, 32'(fml_stb), 0);
    check({tag, "_sel"}, 32'(fml_sel), 0);
    check({tag, "_do"},  32'(fml_do), 0);
    check({tag, "_cack"}, 32'(cpu_fml_ack), 0);
    check({tag, "_lack"}, 32'(lcd_fml_ack), 0);
  endtask

  logic [15:0] beat_d [4];
  logic [1:0]  beat_s [4];

  initial begin
    beat_d = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    beat_s = '{2'b11, 2'b01, 2'b10, 2'b11};
    sys_rst = 1'b1;
    cpu_fml_adr = 20'h0A000; cpu_fml_we = 1'b1;
    cpu_fml_stb = 1'b0; cpu_fml_sel = 2'b11;
    cpu_fml_do = 16'hDEAD;
    lcd_fml_adr = 20'h00100; lcd_fml_we = 1'b0;
    lcd_fml_stb = 1'b0; lcd_fml_sel = 2'b11;
    lcd_fml_do = 16'hBEEF;
    fml_ack = 1'b0; fml_di = 16'h0000;
    cyc(); cyc(); #1;
    check("rst_state", 32'(dut.state), 32'(IDLE));
    check("rst_adr", 32'(fml_adr), 0);
    check("rst_we", 32'(fml_we), 0);
    chk_idle_outs("rst");

    // Tie from reset: LCD first (read).
    cyc();
    cpu_fml_stb = 1'b1; lcd_fml_stb = 1'b1;
    sys_rst = 1'b0;
    cyc(); #1;
    check("lcd_stb", 32'(fml_stb), 1);
    check("lcd_adr", 32'(fml_adr), 32'h00100);
    check("lcd_we", 32'(fml_we), 0);
    for (int i = 0; i < 2; i++) begin
      cyc(); #1;
      check("lcd_wait_stb", 32'(fml_stb), 1);
      check("lcd_wait_ack", 32'(lcd_fml_ack), 0);
    end
    cyc(); fml_ack = 1'b1; #1;
    check("lcd_ack", 32'(lcd_fml_ack), 1);
    check("lcd_cpu_ack", 32'(cpu_fml_ack), 0);
    cyc(); fml_ack = 1'b0; fml_di = 16'hCAFE; #1;
    check("bcast_cpu_di", 32'(cpu_fml_di), 32'hCAFE);
    check("bcast_lcd_di", 32'(lcd_fml_di), 32'hCAFE);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) cyc();
      #1;
      check("lcd_burst_stb", 32'(fml_stb), 0);
      check("lcd_burst_ack", 32'(lcd_fml_ack), 0);
    end
    cyc(); #1;
    check("lcd_after", 32'(dut.state), 32'(IDLE));
    check("lcd_after_stb", 32'(fml_stb), 0);

    // Second tie winner: CPU write.
    cyc(); #1;
    check("cpu_stb", 32'(fml_stb), 1);
    check("cpu_adr", 32'(fml_adr), 32'h0A000);
    check("cpu_we", 32'(fml_we), 1);
    check("pre_do", 32'(fml_do), 0);
    cyc(); fml_ack = 1'b1; #1;
    check("cpu_ack", 32'(cpu_fml_ack), 1);
    check("cpu_lcd_ack", 32'(lcd_fml_ack), 0);
    check("ack_do", 32'(fml_do), 0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      fml_ack = 1'b0; cpu_fml_stb = 1'b0;
      cpu_fml_do = beat_d[i]; cpu_fml_sel = beat_s[i];
      #1;
      check("wr_do", 32'(fml_do), 32'(beat_d[i]));
      check("wr_sel", 32'(fml_sel), 32'(beat_s[i]));
      check("wr_cack", 32'(cpu_fml_ack), 0);
    end
    cyc(); cpu_fml_do = 16'hDEAD; cpu_fml_sel = 2'b11; #1;
    check("post_do", 32'(fml_do), 0);
    check("post_sel", 32'(fml_sel), 0);

    // Third winner LCD; CPU rerequests mid-burst.
    cyc(); #1;
    check("lcd2_stb", 32'(fml_stb), 1);
    check("lcd2_adr", 32'(fml_adr), 32'h00100);
    fml_ack = 1'b1; #1;
    check("lcd2_ack", 32'(lcd_fml_ack), 1);
    check("lcd2_cack", 32'(cpu_fml_ack), 0);
    cyc(); fml_ack = 1'b0; lcd_fml_stb = 1'b0;
    lcd_fml_do = 16'h5A5A; lcd_fml_sel = 2'b10; #1;
    check("lcd2_do", 32'(fml_do), 32'h5A5A);
    check("lcd2_sel", 32'(fml_sel), 2);
    cyc();
    cpu_fml_stb = 1'b1; cpu_fml_adr = 20'h0B000;
    cpu_fml_we = 1'b0;
    cyc(); fml_ack = 1'b1; #1;
    check("burst_ack_cpu", 32'(cpu_fml_ack), 0);
    check("burst_ack_lcd", 32'(lcd_fml_ack), 0);
    cyc(); fml_ack = 1'b0; #1;
    check("burst_ign", 32'(dut.state), 32'(BURST));
    cyc(); #1;
    check("b2b_idle_stb", 32'(fml_stb), 0);
    cyc(); #1;
    check("b2b_stb", 32'(fml_stb), 1);
    check("b2b_adr", 32'(fml_adr), 32'h0B000);
    check("b2b_we", 32'(fml_we), 0);
    cyc(); fml_ack = 1'b1; #1;
    check("b2b_ack", 32'(cpu_fml_ack), 1);
    cyc(); fml_ack = 1'b0; cpu_fml_stb = 1'b0;
    cpu_fml_do = 16'h7777; cpu_fml_sel = 2'b01; #1;
    check("rd_do", 32'(fml_do), 32'h7777);

    // Reset mid-burst.
    cyc(); sys_rst = 1'b1; fml_di = 16'h0000; #1;
    check("mrst_adr", 32'(fml_adr), 0);
    check("mrst_we", 32'(fml_we), 0);
    check("mrst_state", 32'(dut.state), 32'(IDLE));
    chk_idle_outs("mrst");
    cyc(); fml_ack = 1'b1; #1;
    chk_idle_outs("mrst_ack");
    cyc(); fml_ack = 1'b0; sys_rst = 1'b0;

    // Spurious ack in IDLE.
    cyc(); fml_ack = 1'b1; #1;
    check("spur_cack", 32'(cpu_fml_ack), 0);
    check("spur_lack", 32'(lcd_fml_ack), 0);
    cyc(); fml_ack = 1'b0; #1;
    check("spur_state", 32'(dut.state), 32'(IDLE));
    check("spur_stb", 32'(fml_stb), 0);

    // First tie after reset goes to LCD again.
    cpu_fml_adr = 20'h0A000;
    cpu_fml_stb = 1'b1; lcd_fml_stb = 1'b1;
    cyc(); #1;
    check("tie2_stb", 32'(fml_stb), 1);
    check("tie2_adr", 32'(fml_adr), 32'h00100);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_fml_arb.md
Name: vga_fml_arb

Overview:
- FML responder for the two VGA FML masters: the CPU path from the FML bridge and the LCD scan-out path.
- Arbitrates between them and drives one downstream FML master port toward the SDRAM controller.
- Holds the winning master's grant from strobe through the end of its data burst.
- Steers the write-data/select mux during the burst; broadcasts read data to both masters.

Parameters:
- fml_depth, 20, byte address width of the FML ports (1MB video memory).
- burst_len, 4, data beats per FML transaction (16-bit beats); must be a power of two ≥2.

Ports:
- sys_clk  in  1  system clock; all state on rising edge.
- sys_rst  in  1  asynchronous, active-high reset.
- cpu_fml_adr  in  fml_depth  CPU master address.
- cpu_fml_stb  in  1  CPU master strobe; held until ack.
- cpu_fml_we  in  1  CPU master write enable.
- cpu_fml_sel  in  2  CPU master byte selects, per beat.
- cpu_fml_do  in  16  CPU master write data, per beat.
- cpu_fml_ack  out  1  ack to CPU master.
- cpu_fml_di  out  16  read data to CPU master.
- lcd_fml_adr/stb/we/sel/do  in  same widths as the CPU ports  LCD master request.
- lcd_fml_ack  out  1  ack to LCD master.
- lcd_fml_di  out  16  read data to LCD master.
- fml_adr  out  fml_depth  downstream address, registered.
- fml_stb  out  1  downstream strobe.
- fml_we  out  1  downstream write enable, registered.
- fml_ack  in  1  downstream ack.
- fml_sel  out  2  downstream byte selects.
- fml_do  out  16  downstream write data.
- fml_di  in  16  downstream read data.

Behaviour:
- Clocking and reset are fixed: one clock, sys_clk; sys_rst is asynchronous and active-high.
- Reset values:
  - state=IDLE, grant=CPU, last_grant=CPU, beat counter=0.
  - fml_adr=0, fml_we=0, fml_stb=0, fml_sel=0, fml_do=0.
  - cpu_fml_ack=0, lcd_fml_ack=0.
- Reset mid-transaction aborts to IDLE at once; no ack is issued afterwards.
- FML protocol, as seen by every master:
  - stb and adr/we are held stable until the ack cycle.
  - Write beats are presented on the burst_len cycles after ack, one per cycle.
  - Read data arrives on fml_di at downstream-controller latency. cpu_fml_di and lcd_fml_di are fml_di directly (broadcast, no mux).
- State machine:
  - IDLE
    - No request: stay in IDLE.
    - Exactly one request: grant it.
    - Both requesting: grant the master that is not last_grant (round-robin). With last_grant reset to CPU, the LCD wins the first tie.
    - On grant: register fml_adr and fml_we from the winner, set grant and last_grant, go to REQ.
  - REQ
    - fml_stb=1, decoded combinationally from state.
    - On fml_ack: the granted master's ack is driven combinationally in the same cycle; the other master's ack stays 0. Go to BURST with counter=0.
    - REQ has no timeout.
  - BURST
    - fml_sel and fml_do = granted master's sel/do (combinational mux); fml_stb=0.
    - Counter increments each cycle.
    - When counter = burst_len-1: go to IDLE.
    - The state lasts exactly burst_len cycles regardless of we; reads hold BURST as well.
  - Outside BURST: fml_sel=0, fml_do=0.
- Timing, for a request first seen in IDLE at cycle n:
  - fml_stb rises at n+1.
  - ack at cycle m gives write beats at m+1..m+burst_len.
  - Next arbitration at m+burst_len+1; next fml_stb earliest at m+burst_len+2.
- Boundary cases:
  - A request arriving during REQ or BURST waits; it is never dropped.
  - A master deasserting stb before ack is a protocol violation; behaviour is undefined and is not checked.
  - fml_ack while in IDLE or BURST is ignored.
  - The beat counter is log2(burst_len) bits and wraps naturally.

Decomposition:
- Shared package vga_fml_pkg holds:
  - state encoding IDLE/REQ/BURST;
  - grant encoding (GNT_CPU=0, GNT_LCD=1);
  - default burst_len.
- No sub-module; one always block for the FSM/counter and a combinational mux block.

Test Plan:
- Reset: assert sys_rst mid-BURST → every output 0 in the same cycle; after release, IDLE, and an LCD request wins the first tie.
- LCD read: lcd stb, adr=0x00100; downstream ack 3 cycles after fml_stb rises → fml_adr=0x00100, fml_we=0, lcd ack 1 cycle only, cpu ack 0, fml_stb low 4 cycles, IDLE after.
- CPU write: adr=0x0A000, beats 0x1111/0x2222/0x3333/0x4444, sel 11/01/10/11 → fml_do/fml_sel match on ack+1..ack+4; 0 before and after.
- Tie: both stb high from reset → grant order LCD, CPU, LCD; each gets exactly one ack per transaction.
- Back-to-back: CPU stb rises during an LCD BURST → CPU fml_stb asserted exactly 2 cycles after the LCD burst's last beat.
- Spurious ack: pulse fml_ack in IDLE → no master ack, state stays IDLE.
